// File: rtl/fp_compare_pipe_if.sv
// Handshake and data bundle for the FP compare/min-max pipeline.
// master drives operands and OUT_READY; slave is the compare unit.
interface fp_compare_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) ();
    localparam int W = 1 + EXP_W + MAN_W;

    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] OP_A;
    logic [W-1:0] OP_B;
    logic [2:0]   OP_SEL;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] R;
    logic         NV;
    logic         ILLEGAL;

    modport master (
        output IN_VALID, OP_A, OP_B, OP_SEL, OUT_READY,
        input  IN_READY, OUT_VALID, R, NV, ILLEGAL
    );

    modport slave (
        input  IN_VALID, OP_A, OP_B, OP_SEL, OUT_READY,
        output IN_READY, OUT_VALID, R, NV, ILLEGAL
    );
endinterface

// File: rtl/fp_compare_pipe.sv
// Pipelined FEQ/FLT/FLE/FMIN/FMAX unit with NV flag generation.
// Stage 1 classifies and compares; the last stage selects the result.
module fp_compare_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    fp_compare_pipe_if.slave  bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] OP_FEQ = 3'b000;
    localparam logic [2:0] OP_FLT = 3'b001;
    localparam logic [2:0] OP_FLE = 3'b010;
    localparam logic [2:0] OP_MIN = 3'b011;
    localparam logic [2:0] OP_MAX = 3'b100;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic         a_nan;
        logic         b_nan;
        logic         a_snan;
        logic         b_snan;
        logic         zz;
        logic         lt;
        logic         eq;
    } cls_t;

    logic         w_adv;
    logic         w_acc;
    cls_t         w_cls;
    cls_t         w_last;
    logic         w_last_vld;
    logic [W-1:0] w_r;
    logic         w_nv;
    logic         w_ill;
    logic         w_any_nan;
    logic         w_any_snan;
    logic         w_lt_mm;
    logic [W-1:0] w_cnan;

    logic         r_ov;
    logic [W-1:0] r_r;
    logic         r_nv;
    logic         r_ill;

    assign w_adv = bus.OUT_READY | ~r_ov;
    assign w_acc = bus.IN_VALID & w_adv;

    assign bus.IN_READY  = w_adv;
    assign bus.OUT_VALID = r_ov;
    assign bus.R         = r_r;
    assign bus.NV        = r_nv;
    assign bus.ILLEGAL   = r_ill;

    assign w_cnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Stage 1: operand classification and sign-magnitude ordering.
    always_comb begin
        logic a_emax;
        logic b_emax;
        logic a_fz;
        logic b_fz;
        logic a_zero;
        logic b_zero;
        w_cls     = '0;
        w_cls.a   = bus.OP_A;
        w_cls.b   = bus.OP_B;
        w_cls.sel = bus.OP_SEL;
        a_emax    = &bus.OP_A[W-2:MAN_W];
        b_emax    = &bus.OP_B[W-2:MAN_W];
        a_fz      = ~|bus.OP_A[MAN_W-1:0];
        b_fz      = ~|bus.OP_B[MAN_W-1:0];
        a_zero    = ~|bus.OP_A[W-2:MAN_W] & a_fz;
        b_zero    = ~|bus.OP_B[W-2:MAN_W] & b_fz;
        w_cls.a_nan  = a_emax & ~a_fz;
        w_cls.b_nan  = b_emax & ~b_fz;
        w_cls.a_snan = w_cls.a_nan & ~bus.OP_A[MAN_W-1];
        w_cls.b_snan = w_cls.b_nan & ~bus.OP_B[MAN_W-1];
        w_cls.zz     = a_zero & b_zero;
        w_cls.eq     = (bus.OP_A == bus.OP_B) | w_cls.zz;
        if (w_cls.zz) begin
            w_cls.lt = 1'b0;
        end else if (bus.OP_A[W-1] != bus.OP_B[W-1]) begin
            w_cls.lt = bus.OP_A[W-1];
        end else if (!bus.OP_A[W-1]) begin
            w_cls.lt = bus.OP_A[W-2:0] < bus.OP_B[W-2:0];
        end else begin
            w_cls.lt = bus.OP_A[W-2:0] > bus.OP_B[W-2:0];
        end
    end

    generate
        if (STAGES == 1) begin : g_s1
            assign w_last     = w_cls;
            assign w_last_vld = w_acc;
        end else begin : g_sn
            cls_t r_pipe [STAGES-1];
            logic r_vld  [STAGES-1];

            // Plain register stages carrying the classified bundle.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < STAGES-1; i++) begin
                        r_pipe[i] <= '0;
                        r_vld[i]  <= 1'b0;
                    end
                end else if (w_adv) begin
                    r_pipe[0] <= w_cls;
                    r_vld[0]  <= w_acc;
                    for (int i = 1; i < STAGES-1; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                        r_vld[i]  <= r_vld[i-1];
                    end
                end
            end

            assign w_last     = r_pipe[STAGES-2];
            assign w_last_vld = r_vld[STAGES-2];
        end
    endgenerate

    assign w_any_nan  = w_last.a_nan | w_last.b_nan;
    assign w_any_snan = w_last.a_snan | w_last.b_snan;
    // -0 orders below +0 for min/max only.
    assign w_lt_mm = w_last.lt |
                     (w_last.zz & w_last.a[W-1] & ~w_last.b[W-1]);

    // Last stage: result select and NV/ILLEGAL generation.
    always_comb begin
        w_r   = '0;
        w_nv  = 1'b0;
        w_ill = 1'b0;
        case (w_last.sel)
            OP_FEQ: begin
                w_r[0] = ~w_any_nan & w_last.eq;
                w_nv   = w_any_snan;
            end
            OP_FLT: begin
                w_r[0] = ~w_any_nan & w_last.lt;
                w_nv   = w_any_nan;
            end
            OP_FLE: begin
                w_r[0] = ~w_any_nan & (w_last.lt | w_last.eq);
                w_nv   = w_any_nan;
            end
            OP_MIN, OP_MAX: begin
                w_nv = w_any_snan;
                if (w_last.a_nan & w_last.b_nan) begin
                    w_r = w_cnan;
                end else if (w_last.a_nan) begin
                    w_r = w_last.b;
                end else if (w_last.b_nan) begin
                    w_r = w_last.a;
                end else if (w_last.sel == OP_MIN) begin
                    w_r = w_lt_mm ? w_last.a : w_last.b;
                end else begin
                    w_r = w_lt_mm ? w_last.b : w_last.a;
                end
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ov  <= 1'b0;
            r_r   <= '0;
            r_nv  <= 1'b0;
            r_ill <= 1'b0;
        end else if (w_adv) begin
            r_ov <= w_last_vld;
            if (w_last_vld) begin
                r_r   <= w_r;
                r_nv  <= w_nv;
                r_ill <= w_ill;
            end
        end
    end
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed bench for fp_compare_pipe at STAGES = 1, 2 and 4.
// Expected values are hand-computed single-precision results.
module tb_fp_compare_pipe;
    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    localparam logic [2:0] FEQ = 3'b000;
    localparam logic [2:0] FLT = 3'b001;
    localparam logic [2:0] FLE = 3'b010;
    localparam logic [2:0] MIN = 3'b011;
    localparam logic [2:0] MAX = 3'b100;

    fp_compare_pipe_if #(.EXP_W(8), .MAN_W(23)) b1 ();
    fp_compare_pipe_if #(.EXP_W(8), .MAN_W(23)) b2 ();
    fp_compare_pipe_if #(.EXP_W(8), .MAN_W(23)) b4 ();

    fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(1)) u1 (
        .CLK(CLK), .RST(RST), .bus(b1.slave));
    fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2)) u2 (
        .CLK(CLK), .RST(RST), .bus(b2.slave));
    fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(4)) u4 (
        .CLK(CLK), .RST(RST), .bus(b4.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] b);
        b2.IN_VALID = v;
        b2.OP_SEL   = s;
        b2.OP_A     = a;
        b2.OP_B     = b;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        checks++;
        if (b2.OUT_VALID !== 1'b0 || b2.R !== 32'h0 ||
            b2.NV !== 1'b0 || b2.ILLEGAL !== 1'b0) begin
            failures++;
            $display("FAIL reset ov=%b r=%h nv=%b ill=%b want 0/0/0/0",
                     b2.OUT_VALID, b2.R, b2.NV, b2.ILLEGAL);
        end
        checks++;
        if (b2.IN_READY !== 1'b1 || b1.OUT_VALID !== 1'b0 ||
            b4.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy in_ready=%b ov1=%b ov4=%b want 1/0/0",
                     b2.IN_READY, b1.OUT_VALID, b4.OUT_VALID);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_compare();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [2:0]  vs [3];
        logic [31:0] vr [3];
        va = '{32'h3F800000, 32'h40000000, 32'h3F800000};
        vb = '{32'h40000000, 32'h3F800000, 32'h3F800000};
        vs = '{FLT, FLE, FEQ};
        vr = '{32'h1, 32'h0, 32'h1};
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) drive2(1'b1, vs[i], va[i], vb[i]);
            else       drive2(1'b0, FEQ, 32'h0, 32'h0);
            step();
            checks++;
            if (i == 0) begin
                if (b2.OUT_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL cmp_latency ov=%b want 0",
                             b2.OUT_VALID);
                end
            end else if (b2.OUT_VALID !== 1'b1 || b2.R !== vr[i-1] ||
                         b2.NV !== 1'b0 || b2.ILLEGAL !== 1'b0) begin
                failures++;
                $display("FAIL cmp[%0d] ov=%b r=%h nv=%b ill=%b want r=%h",
                         i-1, b2.OUT_VALID, b2.R, b2.NV, b2.ILLEGAL,
                         vr[i-1]);
            end
        end
        step();
        checks++;
        if (b2.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL cmp_drain ov=%b want 0", b2.OUT_VALID);
        end
    endtask

    task automatic test_nan();
        logic [31:0] va [9];
        logic [31:0] vb [9];
        logic [2:0]  vs [9];
        logic [31:0] vr [9];
        logic        vn [9];
        va = '{32'h7FC00000, 32'h7FC00000, 32'h7F800001, 32'hBF800000,
               32'h00000000, 32'h00000000, 32'h80000000, 32'h00000001,
               32'hC0000000};
        vb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
               32'h80000000, 32'h80000000, 32'h00000000, 32'h00000002,
               32'hBF800000};
        vs = '{FEQ, FLT, FEQ, FLE, FLT, FLE, FEQ, FLT, FLT};
        vr = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 32'h1,
               32'h1};
        vn = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i <= 9; i++) begin
            if (i < 9) drive2(1'b1, vs[i], va[i], vb[i]);
            else       drive2(1'b0, FEQ, 32'h0, 32'h0);
            step();
            if (i >= 1) begin
                checks++;
                if (b2.OUT_VALID !== 1'b1 || b2.R !== vr[i-1] ||
                    b2.NV !== vn[i-1] || b2.ILLEGAL !== 1'b0) begin
                    failures++;
                    $display("FAIL nan[%0d] ov=%b r=%h nv=%b ill=%b want r=%h nv=%b",
                             i-1, b2.OUT_VALID, b2.R, b2.NV, b2.ILLEGAL,
                             vr[i-1], vn[i-1]);
                end
            end
        end
        step();
    endtask

    task automatic test_minmax();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [2:0]  vs [8];
        logic [31:0] vr [8];
        logic        vn [8];
        va = '{32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7F800001,
               32'hC0000000, 32'hC0000000, 32'h7F800001, 32'h3F800000};
        vb = '{32'h80000000, 32'h80000000, 32'hC0000000, 32'h7F800001,
               32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h7FC00000};
        vs = '{MIN, MAX, MIN, MAX, MIN, MAX, MAX, MIN};
        vr = '{32'h80000000, 32'h00000000, 32'hC0000000, 32'h7FC00000,
               32'hC0000000, 32'hBF800000, 32'h3F800000, 32'h3F800000};
        vn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive2(1'b1, vs[i], va[i], vb[i]);
            else       drive2(1'b0, FEQ, 32'h0, 32'h0);
            step();
            if (i >= 1) begin
                checks++;
                if (b2.OUT_VALID !== 1'b1 || b2.R !== vr[i-1] ||
                    b2.NV !== vn[i-1] || b2.ILLEGAL !== 1'b0) begin
                    failures++;
                    $display("FAIL minmax[%0d] ov=%b r=%h nv=%b ill=%b want r=%h nv=%b",
                             i-1, b2.OUT_VALID, b2.R, b2.NV, b2.ILLEGAL,
                             vr[i-1], vn[i-1]);
                end
            end
        end
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] va [3];
        logic [2:0]  vs [3];
        va = '{32'h3F800000, 32'h7F800001, 32'h40000000};
        vs = '{3'b111, 3'b101, 3'b110};
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) drive2(1'b1, vs[i], va[i], 32'h7F800001);
            else       drive2(1'b0, FEQ, 32'h0, 32'h0);
            step();
            if (i >= 1) begin
                checks++;
                if (b2.OUT_VALID !== 1'b1 || b2.R !== 32'h0 ||
                    b2.NV !== 1'b0 || b2.ILLEGAL !== 1'b1) begin
                    failures++;
                    $display("FAIL illegal[%0d] ov=%b r=%h nv=%b ill=%b want 1/0/0/1",
                             i-1, b2.OUT_VALID, b2.R, b2.NV, b2.ILLEGAL);
                end
            end
        end
        step();
    endtask

    task automatic test_back_pressure();
        b2.OUT_READY = 1'b0;
        drive2(1'b1, FLT, 32'h3F800000, 32'h40000000);
        step();
        checks++;
        if (b2.OUT_VALID !== 1'b0 || b2.IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL bp_fill ov=%b in_ready=%b want 0/1",
                     b2.OUT_VALID, b2.IN_READY);
        end
        drive2(1'b1, FEQ, 32'h3F800000, 32'h40000000);
        step();
        checks++;
        if (b2.OUT_VALID !== 1'b1 || b2.R !== 32'h1 ||
            b2.IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL bp_first ov=%b r=%h in_ready=%b want 1/1/0",
                     b2.OUT_VALID, b2.R, b2.IN_READY);
        end
        drive2(1'b1, MAX, 32'h3F800000, 32'h40000000);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b2.OUT_VALID !== 1'b1 || b2.R !== 32'h1 ||
                b2.IN_READY !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] ov=%b r=%h in_ready=%b want 1/1/0",
                         i, b2.OUT_VALID, b2.R, b2.IN_READY);
            end
        end
        b2.OUT_READY = 1'b1;
        step();
        drive2(1'b0, FEQ, 32'h0, 32'h0);
        checks++;
        if (b2.OUT_VALID !== 1'b1 || b2.R !== 32'h0) begin
            failures++;
            $display("FAIL bp_drain0 ov=%b r=%h want 1/0",
                     b2.OUT_VALID, b2.R);
        end
        step();
        checks++;
        if (b2.OUT_VALID !== 1'b1 || b2.R !== 32'h40000000) begin
            failures++;
            $display("FAIL bp_drain1 ov=%b r=%h want 1/40000000",
                     b2.OUT_VALID, b2.R);
        end
        step();
        checks++;
        if (b2.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty ov=%b want 0", b2.OUT_VALID);
        end
    endtask

    task automatic test_async_reset();
        drive2(1'b1, FEQ, 32'h3F800000, 32'h3F800000);
        step();
        drive2(1'b1, FLT, 32'h3F800000, 32'h40000000);
        step();
        drive2(1'b0, FEQ, 32'h0, 32'h0);
        checks++;
        if (b2.OUT_VALID !== 1'b1 || b2.R !== 32'h1) begin
            failures++;
            $display("FAIL ar_pre ov=%b r=%h want 1/1",
                     b2.OUT_VALID, b2.R);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (b2.OUT_VALID !== 1'b0 || b2.R !== 32'h0) begin
            failures++;
            $display("FAIL ar_async ov=%b r=%h want 0/0",
                     b2.OUT_VALID, b2.R);
        end
        #1;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b2.OUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL ar_stale[%0d] ov=%b r=%h want ov 0",
                         i, b2.OUT_VALID, b2.R);
            end
        end
    endtask

    task automatic test_latency();
        b1.IN_VALID = 1'b1;
        b1.OP_SEL   = FLT;
        b1.OP_A     = 32'h3F800000;
        b1.OP_B     = 32'h40000000;
        b4.IN_VALID = 1'b1;
        b4.OP_SEL   = FLT;
        b4.OP_A     = 32'h3F800000;
        b4.OP_B     = 32'h40000000;
        step();
        b1.IN_VALID = 1'b0;
        b4.IN_VALID = 1'b0;
        checks++;
        if (b1.OUT_VALID !== 1'b1 || b1.R !== 32'h1 || b1.NV !== 1'b0) begin
            failures++;
            $display("FAIL lat1 ov=%b r=%h nv=%b want 1/1/0",
                     b1.OUT_VALID, b1.R, b1.NV);
        end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (b4.OUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL lat4_early[%0d] ov=%b want 0",
                         k, b4.OUT_VALID);
            end
            step();
            if (k == 1) begin
                checks++;
                if (b1.OUT_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL lat1_once ov=%b want 0", b1.OUT_VALID);
                end
            end
        end
        checks++;
        if (b4.OUT_VALID !== 1'b1 || b4.R !== 32'h1 || b4.NV !== 1'b0) begin
            failures++;
            $display("FAIL lat4 ov=%b r=%h nv=%b want 1/1/0",
                     b4.OUT_VALID, b4.R, b4.NV);
        end
        step();
        checks++;
        if (b4.OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL lat4_once ov=%b want 0", b4.OUT_VALID);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        b1.IN_VALID = 1'b0; b1.OP_A = '0; b1.OP_B = '0;
        b1.OP_SEL   = '0;   b1.OUT_READY = 1'b1;
        b2.IN_VALID = 1'b0; b2.OP_A = '0; b2.OP_B = '0;
        b2.OP_SEL   = '0;   b2.OUT_READY = 1'b1;
        b4.IN_VALID = 1'b0; b4.OP_A = '0; b4.OP_B = '0;
        b4.OP_SEL   = '0;   b4.OUT_READY = 1'b1;
        test_reset();
        test_compare();
        test_nan();
        test_minmax();
        test_illegal();
        test_back_pressure();
        test_async_reset();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
Pipelined, parametrised floating-point compare/min-max unit for the F-extension datapath. It generalises the combinational FEQ/FLT/FLE comparator in three ways:
- parametrised exponent and mantissa widths;
- adds FMIN/FMAX with RISC-V NaN and signed-zero rules, plus the invalid-operation (NV) flag;
- registers the result through a configurable-depth pipeline with valid/ready handshakes on both sides.

It sits between the FP register-file read stage and the FPU result mux / fflags accumulation.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, mantissa (fraction) field width; operand width W = 1+EXP_W+MAN_W
STAGES, 2, pipeline depth in register stages; legal 1..4

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
IN_VALID  input  1  operands and OP_SEL valid
IN_READY  output  1  unit accepts input this cycle
OP_A  input  W  operand A (IEEE-754 format)
OP_B  input  W  operand B
OP_SEL  input  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others illegal
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
R  output  W  result
NV  output  1  invalid-operation flag for this result
ILLEGAL  output  1  OP_SEL was an illegal encoding

Behaviour:
- Reset (async, any time including mid-flight): all stage valid bits cleared; OUT_VALID=0, R=0, NV=0, ILLEGAL=0. In-flight operations are discarded and never reported.
- Pipeline advance: ADV = OUT_READY | ~OUT_VALID. IN_READY = ADV.
  - Every stage shifts when ADV=1 and holds when ADV=0.
  - An input is captured when IN_VALID & IN_READY; otherwise a bubble enters stage 1.
- Latency: exactly STAGES cycles from accept to OUT_VALID when no stall occurs. Throughput is one result per cycle.
- Stall: while OUT_VALID=1 and OUT_READY=0, R, NV and ILLEGAL hold stable and no input is accepted.
- Stage partitioning: classification (NaN, sNaN, zero, sign) and the magnitude compare are computed in stage 1. Result select and flag generation happen in the last stage; intermediate stages are plain registers.
- Operand classes:
  - NaN: exp all-ones and frac≠0.
  - sNaN: NaN with frac MSB=0.
  - Zero: exp=0 and frac=0.
  - +0 and -0 compare equal for FEQ/FLT/FLE.
- Ordering uses sign-magnitude comparison of {exp,frac}. Denormals compare by raw bits; no flushing.
- FEQ/FLT/FLE: R = {W-1 zeros, cmp_bit}. If either operand is NaN, cmp_bit=0.
- NV rules:
  - FEQ: NV=1 only if either operand is sNaN.
  - FLT/FLE: NV=1 if either operand is any NaN.
- FMIN/FMAX:
  - -0 is treated as less than +0.
  - Exactly one operand NaN: R = the other operand.
  - Both operands NaN: R = canonical NaN {0, all-ones exp, 1, zeros}.
  - NV=1 if either operand is sNaN.
- Illegal OP_SEL: R=0, NV=0, ILLEGAL=1. The operation still occupies one pipeline slot and produces OUT_VALID.
- Simultaneous accept and drain in the same cycle is allowed with no bubble.

Test Plan:
- STAGES=2, no stall. Sequence of accepted inputs (OP_A, OP_B, OP_SEL) -> required outputs:
  - FLT, 0x3F800000 (1.0), 0x40000000 (2.0) -> after 2 cycles R=0x00000001, NV=0.
  - FLE, 2.0, 1.0 -> next cycle R=0.
  - FEQ, 1.0, 1.0 -> next cycle R=1.
- FEQ, 0x7FC00000 (qNaN), 1.0 -> R=0, NV=0. FLT with the same operands -> R=0, NV=1. FEQ, 0x7F800001 (sNaN), 1.0 -> R=0, NV=1.
- FMIN:
  - 0x00000000, 0x80000000 -> R=0x80000000.
  - FMAX, same operands -> R=0x00000000.
  - FMIN, qNaN, 0xC0000000 -> R=0xC0000000, NV=0.
  - FMAX, sNaN, sNaN -> R=0x7FC00000, NV=1.
- Back-pressure: hold OUT_READY=0 for 5 cycles with 3 ops issued.
  - IN_READY falls once OUT_VALID=1; R stays stable.
  - When OUT_READY is released, results drain in order, one per cycle, with no loss or duplication.
- Assert RST mid-stream with 2 ops in flight -> OUT_VALID=0 and R=0 immediately (async); no stale result after RST is deasserted.
- OP_SEL=111 -> ILLEGAL=1, R=0 after STAGES cycles. Repeat the FLT test at STAGES=1 and STAGES=4 -> latency 1 and 4 cycles respectively.
